// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one multiplier among N_REQ requesters.
// One operand in flight; the result is returned tagged with the owner id.
module mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int X_W     = 15,
  parameter int M_W     = 26,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*X_W-1:0]   req_x,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   mul_i_valid,
  output logic [X_W-1:0]         mul_x,
  input  logic                   mul_valid,
  input  logic [6*M_W-1:0]       mul_m,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [6*M_W-1:0]       rsp_m,
  output logic                   err_timeout,
  output logic                   err_spurious
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id_reg;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_found;
  logic [X_W-1:0]  x_reg;
  logic [CNT_W-1:0] wait_cnt;

  // search starts just past the last winner, wrapping around
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!gnt_found && req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_found)
      req_ready = N_REQ'(1) << gnt_idx;
  end

  assign mul_x = x_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= ID_W'(N_REQ - 1);
      id_reg       <= '0;
      x_reg        <= '0;
      wait_cnt     <= '0;
      mul_i_valid  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_m        <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      mul_i_valid  <= 1'b0;
      rsp_valid    <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= mul_valid && (state != WAIT);
      unique case (state)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            x_reg       <= req_x[gnt_idx*X_W +: X_W];
            id_reg      <= gnt_idx;
            rr_ptr      <= gnt_idx;
            mul_i_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (mul_valid) begin
            rsp_m     <= mul_m;
            rsp_id    <= id_reg;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed checks of grant order, latency,
// timeout, spurious valid and mid-transaction reset.
module tb_mul_arbiter;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int X_W     = 15;
  localparam int M_W     = 26;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*X_W-1:0] req_x;
  logic [N_REQ-1:0]     req_ready;
  logic                 mul_i_valid;
  logic [X_W-1:0]       mul_x;
  logic                 mul_valid;
  logic [6*M_W-1:0]     mul_m;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [6*M_W-1:0]     rsp_m;
  logic                 err_timeout;
  logic                 err_spurious;

  int n_cmp = 0;
  int n_err = 0;
  logic [6*M_W-1:0] last_m;

  mul_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .X_W(X_W),
    .M_W(M_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready),
    .mul_i_valid(mul_i_valid), .mul_x(mul_x),
    .mul_valid(mul_valid), .mul_m(mul_m),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_m(rsp_m),
    .err_timeout(err_timeout),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [X_W-1:0] x_of(input int i);
    return 15'h0800 + X_W'(i * 'h111);
  endfunction

  function automatic logic [6*M_W-1:0] model(input logic [X_W-1:0] x);
    logic [6*M_W-1:0] r;
    r = '0;
    for (int k = 0; k < 6; k++)
      r[k*M_W +: M_W] = {x, 11'(k * 37 + 5)};
    return r;
  endfunction

  // one full transaction with multiplier latency k; starts in IDLE
  task automatic txn(input logic [N_REQ-1:0] mask,
                     input int id, input int k);
    logic [6*M_W-1:0] m;
    int bad;
    m = model(x_of(id));
    bad = 0;
    req_valid = mask;
    #1;
    chk("grant", req_ready, N_REQ'(1) << id);
    @(negedge clk);
    req_valid = '0;
    chk("issue", mul_i_valid, 1);
    chk("mul_x", mul_x, x_of(id));
    for (int c = 1; c <= k + 1; c++) begin
      if (c > 1 && mul_i_valid) bad++;
      if (rsp_valid || err_timeout || err_spurious) bad++;
      if (req_ready != '0) bad++;
      mul_valid = (c == k + 1);
      mul_m = mul_valid ? m : ~m;
      @(negedge clk);
    end
    mul_valid = 1'b0;
    mul_m = '0;
    chk("quiet", bad, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_m", rsp_m, m);
    last_m = m;
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    req_valid = '0;
    mul_valid = 1'b0;
    mul_m = '0;
    last_m = '0;
    for (int i = 0; i < N_REQ; i++)
      req_x[i*X_W +: X_W] = x_of(i);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out",
        {mul_i_valid, rsp_valid, rsp_id, err_timeout, err_spurious, mul_x},
        0);
    chk("rst_m", rsp_m, 0);

    // single requester, latency 3
    txn(4'b0001, 0, 3);

    // round robin from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(4'b1111, 0, 1);
    txn(4'b1111, 1, 2);
    txn(4'b1111, 2, 1);
    txn(4'b1111, 3, 4);
    txn(4'b1111, 0, 2);

    // wrap-around after grant to 3
    txn(4'b1000, 3, 1);
    txn(4'b0110, 1, 1);
    txn(4'b0110, 2, 2);

    // timeout
    req_valid = 4'b0100;
    #1;
    chk("to_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    bad = 0;
    for (int c = 1; c <= 17; c++) begin
      if (err_timeout || rsp_valid) bad++;
      if (c > 1 && mul_i_valid) bad++;
      @(negedge clk);
    end
    chk("to_quiet", bad, 0);
    chk("to_pulse", err_timeout, 1);
    chk("to_norsp", rsp_valid, 0);
    txn(4'b0001, 0, 2);
    chk("to_clear", err_timeout, 0);

    // spurious mul_valid in IDLE
    mul_valid = 1'b1;
    mul_m = '1;
    @(negedge clk);
    mul_valid = 1'b0;
    mul_m = '0;
    chk("sp_pulse", err_spurious, 1);
    chk("sp_norsp", rsp_valid, 0);
    chk("sp_hold", rsp_m, last_m);
    @(negedge clk);
    chk("sp_clear", err_spurious, 0);
    txn(4'b0010, 1, 1);

    // reset during WAIT
    req_valid = 4'b1000;
    #1;
    chk("rw_grant", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_out",
        {mul_i_valid, rsp_valid, rsp_id, err_timeout, err_spurious, mul_x},
        0);
    chk("rw_m", rsp_m, 0);
    rst_n = 1'b1;
    mul_valid = 1'b1;
    mul_m = model(x_of(3));
    @(negedge clk);
    mul_valid = 1'b0;
    mul_m = '0;
    chk("rw_spur", err_spurious, 1);
    chk("rw_norsp", rsp_valid, 0);
    @(negedge clk);
    chk("rw_norsp2", rsp_valid, 0);
    txn(4'b1111, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
